seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Parametrised, time-multiplexed 7-segment driver for the board's common-anode digit array.
- Successor to the fixed two-value, 8-digit display path; displays one packed N-digit hex value from any design block.
- Adds a programmable refresh rate, per-digit blank and decimal-point masks, and leading-zero suppression.
- Adds tear-free frame snapshots and an anti-ghosting guard interval; runs on the fast board clock, with no divided clock.

Parameters:
- N_DIGITS, 8, number of digits scanned; 1..16.
- REFRESH_DIV, 100000, clock cycles per digit slot; must be ≥2.
- GUARD, 1000, cycles at the start of each slot with all anodes off; 1 ≤ GUARD < REFRESH_DIV.

Ports:
- Clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  4*N_DIGITS  packed nibbles; [3:0] is digit 0 (rightmost).
- blank_mask  in  N_DIGITS  1 = force digit dark.
- dp_mask  in  N_DIGITS  1 = light the decimal point of that digit.
- lz_mode  in  1  1 = leading-zero suppression on.
- out7  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- en_out  out  N_DIGITS  digit anodes, active-low; one-hot-low or all high.
- frame_start  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, idx=0, shadow registers=0.
  - out7=7'h7F, dp=1, en_out=all ones, frame_start=0.
- Prescaler cnt counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and idx advances. idx wraps from N_DIGITS-1 to 0.
- Snapshot:
  - On any cycle with cnt==0 && idx==0, data_in, blank_mask, dp_mask and lz_mode load into shadow at the next edge.
  - frame_start is 1 for exactly that following cycle.
  - This includes the first cycle after reset release.
  - Frame period = N_DIGITS*REFRESH_DIV cycles.
  - Input changes mid-frame are ignored until the next snapshot.
- Outputs are registered and reflect the cnt/idx state of the previous cycle (1-cycle latency).
- en_out rules:
  - cnt < GUARD → all ones.
  - Otherwise, en_out[idx]=0 and all other bits are 1.
  - GUARD ≥ 1 guarantees anodes are off on the edge where the shadow changes, so there is no torn digit.
- out7 rules:
  - Digit blanked → 7'h7F.
  - Otherwise → hex encoding of shadow nibble idx:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- A digit is blanked when either:
  - its shadow blank_mask bit is 1; or
  - shadow lz_mode=1, idx≠0, and nibbles idx..N_DIGITS-1 are all zero.
- Digit 0 is never LZ-blanked; value 0 shows a single "0".
- dp = ~shadow dp_mask[idx], independent of blanking.
- N_DIGITS=1: idx is constant 0, a snapshot occurs every REFRESH_DIV cycles, and LZ has no effect.
- Reset asserted mid-frame:
  - Outputs go to reset values immediately (async).
  - After release, scanning restarts at digit 0 with a fresh snapshot.

Decomposition:
- Shared package seg7_pkg:
  - SEG_BLANK (7'h7F) constant.
  - 16-entry hex segment constant table.
  - Function clog2-safe index width.
- One sub-module, hex_to_seg7: combinational 4-bit → 7-bit active-low decoder, reused by other display blocks.
- Prescaler, scan counter, shadow registers and LZ logic stay in seg_scan_display.

Test Plan (N_DIGITS=8, REFRESH_DIV=4, GUARD=1 unless stated):
- Reset release with data_in=32'h0000_0000, lz_mode=0:
  - frame_start pulses on cycle 1, then every 32 cycles.
  - en_out sequence per slot: FF, FE, FE, FE, FF, FD, FD, FD, ...
  - out7=1000000 whenever an anode is on.
- data_in=32'h89AB_CDEF, lz_mode=0: digits 0..7 show F, E, d, C, b, A, 9, 8 with the exact codes above; dp stays 1.
- data_in=32'h0000_0A05, lz_mode=1:
  - digits 0..2 show 5, 0, A.
  - digits 3..7 out7=7F.
- data_in=0 with lz_mode=1: only digit 0 shows 1000000.
- data_in changes from 32'h1111_1111 to 32'h2222_2222 during digit 3's slot:
  - digits 4..7 still show 1 for that frame.
  - all digits show 2 after the next frame_start.
- blank_mask=8'h81, dp_mask=8'h02:
  - digits 0 and 7 out7=7F.
  - dp=0 only while en_out=FD.
- Reset asserted mid-slot at idx=5: out7=7F, en_out=FF and dp=1 in the same cycle.
- Reset released: first enabled anode is FE, after one guard cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment display blocks.
//   SEG_BLANK : all segments dark (active-low {g,f,e,d,c,b,a}).
//   SEG_HEX   : 16-entry hex glyph table, indexed by nibble value.
//   idx_width : counter/index width that stays >= 1 for degenerate sizes.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyphs 0-9, A, b, C, d, E, F; bit order {g,f,e,d,c,b,a}, 0 = segment lit.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // $clog2 returns 0 for n==1, which would give a zero-width vector.
  function automatic int idx_width(input int n);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational 4-bit to 7-segment (active-low) decoder.
//   nibble : hex value 0..F
//   seg    : segments {g,f,e,d,c,b,a}, 0 = lit
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup; every nibble value has a glyph.
  always_comb begin
    seg = SEG_HEX[nibble];
  end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed common-anode 7-segment driver.
//   Clk, rst    : clock, asynchronous active-high reset
//   data_in     : packed hex nibbles, [3:0] = digit 0 (rightmost)
//   blank_mask  : 1 = digit forced dark
//   dp_mask     : 1 = decimal point lit on that digit
//   lz_mode     : 1 = leading-zero suppression
//   out7, dp    : active-low segments / decimal point (registered)
//   en_out      : active-low anodes, one-hot-low or all high (registered)
//   frame_start : one-cycle pulse when the input snapshot is taken
// Inputs are sampled once per frame into shadow registers so a value that
// changes mid-frame can never show as a mix of old and new digits.
module seg_scan_display
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 32'sd8,
  parameter int REFRESH_DIV = 32'sd100000,
  parameter int GUARD       = 32'sd1000
) (
  input  logic                  Clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic                  lz_mode,
  output logic [6:0]            out7,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   en_out,
  output logic                  frame_start
);

  localparam int CW = idx_width(REFRESH_DIV);
  localparam int IW = idx_width(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 32'sd1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 32'sd1);

  logic [CW-1:0]       cnt_r;
  logic [IW-1:0]       idx_r;
  logic [3:0]          shadow_nib_r [N_DIGITS];
  logic [N_DIGITS-1:0] shadow_blank_r;
  logic [N_DIGITS-1:0] shadow_dp_r;
  logic                shadow_lz_r;

  logic                snap_s;
  logic [N_DIGITS-1:0] zero_above_s;
  logic                blank_s;
  logic [3:0]          cur_nib_s;
  logic [6:0]          cur_seg_s;
  logic [N_DIGITS-1:0] en_s;

  assign snap_s    = (cnt_r == {CW{1'b0}}) && (idx_r == {IW{1'b0}});
  assign cur_nib_s = shadow_nib_r[idx_r];

  hex_to_seg7 u_dec (
    .nibble (cur_nib_s),
    .seg    (cur_seg_s)
  );

  // zero_above_s[i] = 1 when nibbles i..N_DIGITS-1 are all zero.
  always_comb begin
    logic run_s;
    zero_above_s = {N_DIGITS{1'b0}};
    run_s        = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run_s           = run_s & (shadow_nib_r[i] == 4'h0);
      zero_above_s[i] = run_s;
    end
  end

  // Blank decision; digit 0 is never suppressed so zero shows as "0".
  always_comb begin
    if (shadow_blank_r[idx_r]) begin
      blank_s = 1'b1;
    end else if (shadow_lz_r && (idx_r != {IW{1'b0}}) && zero_above_s[idx_r]) begin
      blank_s = 1'b1;
    end else begin
      blank_s = 1'b0;
    end
  end

  // Anodes stay off for the guard window so the segment bus settles first.
  always_comb begin
    en_s = {N_DIGITS{1'b1}};
    if (cnt_r >= GUARD_END) begin
      en_s[idx_r] = 1'b0;
    end else begin
      en_s = {N_DIGITS{1'b1}};
    end
  end

  // Slot prescaler and digit scan index.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= {IW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CW{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_r <= {IW{1'b0}};
      end else begin
        idx_r <= idx_r + IW'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  // Frame snapshot of all display inputs plus its strobe.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        shadow_nib_r[i] <= 4'h0;
      end
      shadow_blank_r <= {N_DIGITS{1'b0}};
      shadow_dp_r    <= {N_DIGITS{1'b0}};
      shadow_lz_r    <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      frame_start <= snap_s;
      if (snap_s) begin
        for (int i = 0; i < N_DIGITS; i++) begin
          shadow_nib_r[i] <= data_in[4*i +: 4];
        end
        shadow_blank_r <= blank_mask;
        shadow_dp_r    <= dp_mask;
        shadow_lz_r    <= lz_mode;
      end
    end
  end

  // Registered pin drivers, one cycle behind cnt/idx.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      out7   <= SEG_BLANK;
      dp     <= 1'b1;
      en_out <= {N_DIGITS{1'b1}};
    end else begin
      out7   <= blank_s ? SEG_BLANK : cur_seg_s;
      dp     <= ~shadow_dp_r[idx_r];
      en_out <= en_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed self-checking bench for seg_scan_display
// with N_DIGITS=8, REFRESH_DIV=4, GUARD=1 (frame = 32 cycles).
module tb_seg_scan_display;

  logic        Clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = 32'h0;
  logic [7:0]  blank_mask = 8'h0;
  logic [7:0]  dp_mask = 8'h0;
  logic        lz_mode = 1'b0;
  logic [6:0]  out7;
  logic        dp;
  logic [7:0]  en_out;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [7:0] en_seq [8] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD};

  logic [6:0] seg_cap [8];
  logic       dp_cap  [8];
  logic [7:0] en_cap  [8];

  seg_scan_display #(
    .N_DIGITS    (8),
    .REFRESH_DIV (4),
    .GUARD       (1)
  ) dut (
    .Clk         (Clk),
    .rst         (rst),
    .data_in     (data_in),
    .blank_mask  (blank_mask),
    .dp_mask     (dp_mask),
    .lz_mode     (lz_mode),
    .out7        (out7),
    .dp          (dp),
    .en_out      (en_out),
    .frame_start (frame_start)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Advance to the sample where frame_start is high (bounded).
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < 100);
    check_eq("frame_start_seen", {31'h0, frame_start}, 32'h1);
  endtask

  // Called right after the frame_start sample; records each digit while lit.
  task automatic capture_frame(input int chg_d, input logic [31:0] chg_val);
    for (int d = 0; d < 8; d++) begin
      if (d > 0) step();
      step();
      seg_cap[d] = out7;
      dp_cap[d]  = dp;
      en_cap[d]  = en_out;
      if (d == chg_d) data_in = chg_val;
      step();
      step();
    end
  endtask

  task automatic check_digits(input string name, input logic [31:0] val,
                              input logic [7:0] dark, input logic [7:0] dpm);
    logic [3:0] nib;
    logic [7:0] one;
    for (int d = 0; d < 8; d++) begin
      nib = val[4*d +: 4];
      one = 8'h01 << d;
      check_eq($sformatf("%s_en%0d", name, d), {24'h0, en_cap[d]}, {24'h0, ~one});
      check_eq($sformatf("%s_seg%0d", name, d), {25'h0, seg_cap[d]},
               {25'h0, dark[d] ? 7'h7F : seg_tbl[nib]});
      check_eq($sformatf("%s_dp%0d", name, d), {31'h0, dp_cap[d]}, {31'h0, ~dpm[d]});
    end
  endtask

  initial begin
    // Reset state while held.
    step();
    step();
    check_eq("rst_out7", {25'h0, out7}, 32'h7F);
    check_eq("rst_dp", {31'h0, dp}, 32'h1);
    check_eq("rst_en", {24'h0, en_out}, 32'hFF);
    check_eq("rst_fs", {31'h0, frame_start}, 32'h0);

    // Release: first frame, zeros, lz off.
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_eq($sformatf("seq_fs%0d", k), {31'h0, frame_start}, (k == 1) ? 32'h1 : 32'h0);
      check_eq($sformatf("seq_en%0d", k), {24'h0, en_out}, {24'h0, en_seq[k-1]});
      if (en_seq[k-1] != 8'hFF)
        check_eq($sformatf("seq_seg%0d", k), {25'h0, out7}, 32'h40);
    end
    for (int k = 9; k <= 32; k++) step();
    check_eq("fs_c32", {31'h0, frame_start}, 32'h0);
    step();
    check_eq("fs_c33", {31'h0, frame_start}, 32'h1);

    // Full hex glyph set, no suppression.
    data_in = 32'h89AB_CDEF;
    wait_frame();
    capture_frame(-1, 32'h0);
    check_digits("hex", 32'h89AB_CDEF, 8'h00, 8'h00);

    // Leading-zero suppression with an embedded zero.
    data_in = 32'h0000_0A05;
    lz_mode = 1'b1;
    wait_frame();
    capture_frame(-1, 32'h0);
    check_digits("lz", 32'h0000_0A05, 8'hF8, 8'h00);

    // All-zero value with suppression: only digit 0 lit.
    data_in = 32'h0;
    wait_frame();
    capture_frame(-1, 32'h0);
    check_digits("lz0", 32'h0, 8'hFE, 8'h00);

    // Mid-frame input change is held off until the next snapshot.
    data_in = 32'h1111_1111;
    lz_mode = 1'b0;
    wait_frame();
    capture_frame(3, 32'h2222_2222);
    check_digits("tear_old", 32'h1111_1111, 8'h00, 8'h00);
    wait_frame();
    capture_frame(-1, 32'h0);
    check_digits("tear_new", 32'h2222_2222, 8'h00, 8'h00);

    // Blank and decimal-point masks.
    data_in    = 32'h1234_5678;
    blank_mask = 8'h81;
    dp_mask    = 8'h02;
    wait_frame();
    capture_frame(-1, 32'h0);
    check_digits("mask", 32'h1234_5678, 8'h81, 8'h02);

    // Asynchronous reset in the middle of digit 5's slot.
    blank_mask = 8'h00;
    dp_mask    = 8'h20;
    wait_frame();
    for (int k = 0; k < 21; k++) step();
    check_eq("pre_rst_en", {24'h0, en_out}, 32'hDF);
    check_eq("pre_rst_dp", {31'h0, dp}, 32'h0);
    rst = 1'b1;
    #1;
    check_eq("arst_out7", {25'h0, out7}, 32'h7F);
    check_eq("arst_en", {24'h0, en_out}, 32'hFF);
    check_eq("arst_dp", {31'h0, dp}, 32'h1);
    check_eq("arst_fs", {31'h0, frame_start}, 32'h0);
    step();
    step();
    check_eq("arst_hold_en", {24'h0, en_out}, 32'hFF);
    rst = 1'b0;
    step();
    check_eq("rel_fs", {31'h0, frame_start}, 32'h1);
    check_eq("rel_en_guard", {24'h0, en_out}, 32'hFF);
    step();
    check_eq("rel_en_first", {24'h0, en_out}, 32'hFE);
    check_eq("rel_seg_first", {25'h0, out7}, {25'h0, seg_tbl[8]});
    check_eq("rel_dp_first", {31'h0, dp}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
